// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: memory-side initiator for the LC-3 datapath.
// This block owns the MAR and MDR registers. It turns the MIO_EN/R_W request
// into one chip-select cycle on the synchronous RAM port, and it returns the
// R (memory-ready) level to the control FSM. All RAM-side outputs are Moore
// outputs decoded from the state register.
// Optional feature: define MEM_TIMEOUT_EN to abort reads that are not
// answered within TIMEOUT wait cycles. An aborted read loads MDR with 16'hDEAD
// and sets MEM_ERR.
module lc3_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] BUS_IN,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DIN,
  output logic        MEM_CS,
  output logic        MEM_WE,
  input  logic [15:0] MEM_DOUT,
  input  logic        MEM_READY,
  output logic        R,
  output logic        BUSY,
  output logic        MEM_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [15:0] mar, mdr;
  logic        ld_ok;        // the bus may load MAR/MDR only when no access is in flight
  logic        accept;       // a new request is taken in IDLE
  logic        rd_capture;   // RAM read data arrives in RD_WAIT
  logic        timeout_hit;  // an unanswered read is abandoned

  assign ld_ok      = (state == IDLE) || (state == DONE);
  assign accept     = (state == IDLE) && MIO_EN;
  assign rd_capture = (state == RD_WAIT) && MEM_READY;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        mem_err_q;

  // Counts the cycles spent in RD_WAIT. The count restarts on every new read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (state == RD_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == RD_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Ready takes priority. A timeout fires only when no ready arrives by the last wait cycle.
  assign timeout_hit = (state == RD_WAIT) && !MEM_READY && (wait_cnt == 16'(TIMEOUT - 1));

  // The error flag is set when a read is aborted. It is cleared when the next request is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_err_q <= 1'b0;
    end else if (accept) begin
      mem_err_q <= 1'b0;
    end else if (timeout_hit) begin
      mem_err_q <= 1'b1;
    end
  end

  assign MEM_ERR = mem_err_q;
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign MEM_ERR        = 1'b0;
`endif

  // State register. An asynchronous reset drops CS at once, even in the middle of an access.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode for the request/handshake sequence.
  // NOTE: next_state gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (MIO_EN) next_state = R_W ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  if (MEM_READY || timeout_hit) next_state = DONE;
      WR_ISSUE: next_state = DONE;
      DONE:     if (!MIO_EN) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // MAR follows the bus only while no access is in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mar <= '0;
    end else if (LD_MAR && ld_ok) begin
      mar <= BUS_IN;
    end
  end

  // MDR load priority: RAM read data first, then the timeout marker, then a bus load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mdr <= '0;
    end else if (rd_capture) begin
      mdr <= MEM_DOUT;
    end else if (timeout_hit) begin
      mdr <= 16'hDEAD;
    end else if (LD_MDR && ld_ok) begin
      mdr <= BUS_IN;
    end
  end

  assign MAR_OUT  = mar;
  assign MDR_OUT  = mdr;
  assign MEM_ADDR = mar;
  assign MEM_DIN  = mdr;
  assign MEM_CS   = (state == RD_ISSUE) || (state == WR_ISSUE);
  assign MEM_WE   = (state == WR_ISSUE);
  assign BUSY     = (state == RD_ISSUE) || (state == RD_WAIT) || (state == WR_ISSUE);
  assign R        = (state == DONE);

endmodule
